mem_access_unit: RTL and testbench

Load/store sequencer placed directly upstream of the 32 × 8-bit data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and range-checks the address. It then drives the memory's read/write strobes, address and write data for exactly one cycle. It absorbs the memory's one-cycle registered read latency and returns a response to the requester over a valid/ready handshake.

---
 rtl/mem_access_unit.sv | 103 ++++++++++
 tb/tb_mem_access_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer in front of a 32 x 8-bit registered-read data memory
module mem_access_unit #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [7:0]            req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  signal_memread,
  output logic                  signal_memwrite,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_to_write,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // Nine bits so DEPTH = 256 still compares correctly against an 8-bit address.
  localparam logic [8:0] DEPTH_LIMIT = 9'(DEPTH);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       accept;
  logic       addr_illegal;

  assign accept       = req_valid && (state == S_IDLE);
  assign addr_illegal = ({1'b0, req_addr} >= DEPTH_LIMIT);

  // Every handshake and strobe output is a pure decode of the registered state,
  // so an asynchronous clear drops them immediately.
  assign req_ready       = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign resp_valid      = (state == S_RESP);
  assign signal_memwrite = (state == S_WRITE);
  assign signal_memread  = (state == S_READ);

  // Next-state selection for the request/strobe/capture/response sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (addr_illegal)   state_next = S_RESP;
          else if (req_write) state_next = S_WRITE;
          else                state_next = S_READ;
        end
      end
      S_WRITE:   state_next = S_RESP;
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_RESP;
      S_RESP:    if (resp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_next;
  end

  // Memory-side address/data latch; only legal requests reach the memory bus,
  // and the values are held between operations.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mem_address       <= '0;
      mem_data_to_write <= '0;
    end else if (accept && !addr_illegal) begin
      mem_address       <= req_addr[ADDR_WIDTH-1:0];
      mem_data_to_write <= req_wdata;
    end
  end

  // Response payload: cleared on acceptance (stores and errors return 0),
  // filled from the memory one cycle after the read strobe, frozen in RESP.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (accept) begin
      resp_rdata <= '0;
      resp_error <= addr_illegal;
    end else if (state == S_CAPTURE) begin
      resp_rdata <= mem_data_out;
      resp_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic       clock = 1'b0;
  logic       clear;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       resp_valid, resp_ready, resp_error;
  logic [7:0] resp_rdata;
  logic       signal_memread, signal_memwrite;
  logic [4:0] mem_address;
  logic [7:0] mem_data_to_write, mem_data_out;
  logic       busy;

  logic [7:0] dmem    [32];
  logic [7:0] ref_mem [32];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .signal_memread(signal_memread), .signal_memwrite(signal_memwrite),
    .mem_address(mem_address), .mem_data_to_write(mem_data_to_write),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // Data memory with one-cycle registered read.
  always @(posedge clock) begin
    if (signal_memwrite) dmem[mem_address] <= mem_data_to_write;
    if (signal_memread)  mem_data_out <= dmem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transaction. hold = extra cycles of resp_ready low after the first RESP cycle
  // (hold > 0 keeps it low in the first RESP cycle too).
  task automatic run_op(input bit wr, input logic [7:0] addr, input logic [7:0] wd, input int hold);
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_lat, lat, nrd, nwr, nboth, rd_cyc, wr_cyc;
    logic [7:0] s_rd;
    logic       s_err;
    if (addr >= 8'd32) begin
      exp_err = 1'b1; exp_rd = 8'h00; exp_lat = 1;
    end else if (wr) begin
      exp_err = 1'b0; exp_rd = 8'h00; exp_lat = 2; ref_mem[addr[4:0]] = wd;
    end else begin
      exp_err = 1'b0; exp_rd = ref_mem[addr[4:0]]; exp_lat = 3;
    end
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    resp_ready = (hold == 0);
    lat = 0; nrd = 0; nwr = 0; nboth = 0; rd_cyc = 0; wr_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (signal_memread && signal_memwrite) nboth++;
      if (signal_memread) begin
        nrd++; rd_cyc = c;
        check("rd_addr", mem_address, addr[4:0]);
      end
      if (signal_memwrite) begin
        nwr++; wr_cyc = c;
        check("wr_addr", mem_address, addr[4:0]);
        check("wr_data", mem_data_to_write, wd);
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("strobe_both", nboth, 0);
    check("rd_strobes", nrd, (!exp_err && !wr) ? 1 : 0);
    check("wr_strobes", nwr, (!exp_err && wr) ? 1 : 0);
    if (nrd > 0) check("rd_cycle", rd_cyc, 1);
    if (nwr > 0) check("wr_cycle", wr_cyc, 1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_error", resp_error, exp_err);
    s_rd = resp_rdata; s_err = resp_error;
    if (hold > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd3; req_wdata = 8'hFF;
      repeat (hold) begin
        @(negedge clock);
        check("hold_valid", resp_valid, 1);
        check("hold_rdata", resp_rdata, s_rd);
        check("hold_error", resp_error, s_err);
        check("hold_req_ready", req_ready, 0);
        check("hold_strobes", {signal_memread, signal_memwrite}, 0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clock);
    check("idle_req_ready", req_ready, 1);
    check("idle_resp_valid", resp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 8'($urandom);
      dmem[i]    = ref_mem[i];
    end
    ref_mem[9] = 8'h11;
    dmem[9]    = 8'h11;
    mem_data_out = 8'h00;
    clear = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; resp_ready = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_memread", signal_memread, 0);
    check("rst_memwrite", signal_memwrite, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_data_to_write, 0);
    clear = 1'b1;
    @(negedge clock);

    run_op(1'b1, 8'd5, 8'hA7, 0);
    run_op(1'b0, 8'd5, 8'h00, 0);
    run_op(1'b0, 8'd40, 8'h00, 0);
    run_op(1'b0, 8'd31, 8'h00, 5);

    // Store to 9 aborted by clear during its WRITE cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd9; req_wdata = 8'h3C; resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    check("abort_wr_seen", signal_memwrite, 1);
    #1 clear = 1'b0;
    #1;
    check("abort_wr_drop", signal_memwrite, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_mem_address", mem_address, 0);
    @(negedge clock);
    clear = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("abort_no_resp", resp_valid, 0);
    end
    check("abort_mem9", dmem[9], 8'h11);
    run_op(1'b0, 8'd9, 8'h00, 0);

    for (int n = 0; n < 200; n++) begin
      run_op(1'($urandom), 8'($urandom_range(0, 47)), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    for (int i = 0; i < 32; i++) check("final_mem", dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
